hazard_scoreboard_unit: RTL and testbench

//  Parametrised successor to the ID-stage load-use hazard detector. Holds a per-register

---
 rtl/hazard_pkg.sv | 15 +
 rtl/scoreboard_entry.sv | 33 +++
 rtl/hazard_scoreboard_unit.sv | 76 +++++++
 tb/tb_hazard_scoreboard_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int LAT_LOAD       = 2;
  localparam int LAT_NOFWD      = 3;

  // Countdown width wide enough to hold the longest wait; never narrower than 1 bit.
  function automatic int lat_cnt_w(input int load_lat, input int nofwd_lat);
    int max_lat;
    max_lat = (load_lat > nofwd_lat) ? load_lat : nofwd_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One countdown cell of the hazard scoreboard: cycles until its register is safe to read.
module scoreboard_entry #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [LAT_W-1:0] lat,
  input  logic             freeze,
  input  logic             clear,
  output logic             pending
);

  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_dec;

  assign w_dec = (r_cnt != '0) ? r_cnt - LAT_W'(1) : '0;

  // NOTE: state uses non-blocking assignments so every cell samples the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (!freeze) begin
      // A newer writer may extend the wait but never shorten it.
      r_cnt <= (set && (lat > w_dec)) ? lat : w_dec;
    end
  end

  assign pending = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage scoreboard: stalls ID while any used source register has a pending write.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W    = DEF_REG_ADDR_W,
  parameter int LOAD_LATENCY  = LAT_LOAD,
  parameter int NOFWD_LATENCY = LAT_NOFWD,
  parameter int FORWARD_EN    = 1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src1_used,
  input  logic                  src2_used,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int LAT_W    = lat_cnt_w(LOAD_LATENCY, NOFWD_LATENCY);

  logic [NUM_REGS-1:0] w_pending;
  logic [LAT_W-1:0]    w_lat;
  logic                w_src1_hit;
  logic                w_src2_hit;
  logic                w_issue;
  logic [CNT_W-1:0]    r_stall_count;

  // r0 is hard-wired zero, so it never has a pending write.
  assign w_pending[0] = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
    scoreboard_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .set     (w_issue && (id_dest == REG_ADDR_W'(g))),
      .lat     (w_lat),
      .freeze  (freeze),
      .clear   (flush),
      .pending (w_pending[g])
    );
  end

  assign w_src1_hit      = src1_used && (src1 != '0) && w_pending[src1];
  assign w_src2_hit      = src2_used && (src2 != '0) && w_pending[src2];
  assign hazard_detected = id_valid && (w_src1_hit || w_src2_hit);

  assign w_lat = (FORWARD_EN != 0) ? (id_mem_read ? LAT_W'(LOAD_LATENCY) : '0)
                                   : LAT_W'(NOFWD_LATENCY);

  assign w_issue = id_valid && !hazard_detected && !freeze && id_wb_en && (id_dest != '0);

  assign busy = |w_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (hazard_detected && !freeze && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: three configurations share one stimulus stream.
module tb_hazard_scoreboard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] src1, src2, id_dest;
  logic       src1_used, src2_used, id_wb_en, id_mem_read, freeze, flush;

  logic        haz_a, busy_a, haz_b, busy_b, haz_c, busy_c;
  logic [15:0] sc_a, sc_b;
  logic [3:0]  sc_c;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: remaining wait cycles per register, one set per configuration.
  int m_cnt[3][32];
  int m_stall[3];
  int m_fwd[3] = '{1, 0, 1};
  int m_max[3] = '{65535, 65535, 15};

  hazard_scoreboard_unit #(.FORWARD_EN(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .freeze(freeze), .flush(flush),
    .hazard_detected(haz_a), .busy(busy_a), .stall_count(sc_a));

  hazard_scoreboard_unit #(.FORWARD_EN(0), .NOFWD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .freeze(freeze), .flush(flush),
    .hazard_detected(haz_b), .busy(busy_b), .stall_count(sc_b));

  hazard_scoreboard_unit #(.FORWARD_EN(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .freeze(freeze), .flush(flush),
    .hazard_detected(haz_c), .busy(busy_c), .stall_count(sc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] s1;
    logic       u1;
    logic [4:0] s2;
    logic       u2;
    logic [4:0] d;
    logic       wb;
    logic       mr;
    logic       e_haz;
    logic       e_busy;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_haz(int k);
    bit h1, h2;
    h1 = src1_used && (src1 != 0) && (m_cnt[k][src1] > 0);
    h2 = src2_used && (src2 != 0) && (m_cnt[k][src2] > 0);
    return id_valid && (h1 || h2);
  endfunction

  function automatic bit m_busy(int k);
    for (int r = 0; r < 32; r++) if (m_cnt[k][r] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Next-state of the model, evaluated just after the rising edge with the same inputs.
  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit h, iss;
      int lat;
      h   = m_haz(k);
      iss = id_valid && !h && !freeze && id_wb_en && (id_dest != 0);
      lat = m_fwd[k] ? (id_mem_read ? 2 : 0) : 3;
      if (rst) begin
        for (int r = 0; r < 32; r++) m_cnt[k][r] = 0;
        m_stall[k] = 0;
      end else begin
        if (h && !freeze && m_stall[k] < m_max[k]) m_stall[k]++;
        if (flush) begin
          for (int r = 0; r < 32; r++) m_cnt[k][r] = 0;
        end else if (!freeze) begin
          for (int r = 0; r < 32; r++) if (m_cnt[k][r] > 0) m_cnt[k][r]--;
          if (iss && lat > m_cnt[k][id_dest]) m_cnt[k][id_dest] = lat;
        end
      end
    end
  endtask

  // Called one time unit after inputs settle: compare all DUTs to the model, then clock.
  task automatic tick();
    check("a_haz_model",  32'(haz_a),  32'(m_haz(0)));
    check("a_busy_model", 32'(busy_a), 32'(m_busy(0)));
    check("a_cnt_model",  32'(sc_a),   32'(m_stall[0]));
    check("b_haz_model",  32'(haz_b),  32'(m_haz(1)));
    check("b_busy_model", 32'(busy_b), 32'(m_busy(1)));
    check("b_cnt_model",  32'(sc_b),   32'(m_stall[1]));
    check("c_haz_model",  32'(haz_c),  32'(m_haz(2)));
    check("c_busy_model", 32'(busy_c), 32'(m_busy(2)));
    check("c_cnt_model",  32'(sc_c),   32'(m_stall[2]));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input logic vld, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input logic [4:0] d,
                        input logic wb, input logic mr, input logic frz, input logic fl);
    id_valid = vld; src1 = s1; src1_used = u1; src2 = s2; src2_used = u2;
    id_dest = d; id_wb_en = wb; id_mem_read = mr; freeze = frz; flush = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // vld s1 u1 s2 u2 d wb mr | haz busy stall  (expectations for the default configuration)
    vecs[0]  = '{1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0};  // load r5
    vecs[1]  = '{1, 5, 1, 1, 1, 6, 1, 0, 1, 1, 0};  // add r6,r5,r1 stalls
    vecs[2]  = '{1, 5, 1, 1, 1, 6, 1, 0, 1, 1, 1};
    vecs[3]  = '{1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 2};  // third cycle: ready
    vecs[4]  = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 2};  // ALU write r7
    vecs[5]  = '{1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 2};  // reads r7 twice, forwarded
    vecs[6]  = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 2};  // load to r0 reading r0
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
    vecs[8]  = '{1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 2};  // load r5
    vecs[9]  = '{1, 1, 1, 5, 0, 0, 0, 0, 0, 1, 2};  // src2 = r5 but unused
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
    vecs[12] = '{1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 2};  // load r5
    vecs[13] = '{0, 5, 1, 5, 1, 0, 0, 0, 0, 1, 2};  // bubble reading r5: no stall

    idle();
    do_reset();

    // Reset state
    #1;
    check("reset_haz",   32'(haz_a),  32'd0);
    check("reset_busy",  32'(busy_a), 32'd0);
    check("reset_stall", 32'(sc_a),   32'd0);
    check("reset_stall_c", 32'(sc_c), 32'd0);
    tick();

    // Table-driven sequence: load-use, forwarding, r0, unused source, bubble
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].vld, vecs[i].s1, vecs[i].u1, vecs[i].s2, vecs[i].u2, vecs[i].d,
             vecs[i].wb, vecs[i].mr, 1'b0, 1'b0);
      #1;
      check($sformatf("vec%0d_haz", i),   32'(haz_a),  32'(vecs[i].e_haz));
      check($sformatf("vec%0d_busy", i),  32'(busy_a), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_stall", i), 32'(sc_a),   32'(vecs[i].e_stall));
      tick();
    end

    // No forwarding: ALU result costs 3 stall cycles
    do_reset();
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    #1; tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
      #1;
      check($sformatf("nofwd_haz%0d", i),   32'(haz_b), (i < 3) ? 32'd1 : 32'd0);
      check($sformatf("nofwd_stall%0d", i), 32'(sc_b),  32'(i));
      check($sformatf("fwd_haz%0d", i),     32'(haz_a), 32'd0);
      tick();
    end

    // Freeze holds the countdown and the statistics counter
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    #1; tick();
    for (int i = 0; i < 7; i++) begin
      set_in(1, 5, 1, 0, 0, 6, 1, 0, (i < 4), 0);
      #1;
      check($sformatf("frz_haz%0d", i),   32'(haz_a), (i < 6) ? 32'd1 : 32'd0);
      check($sformatf("frz_stall%0d", i), 32'(sc_a),  (i < 5) ? 32'd0 : 32'(i - 4));
      tick();
    end

    // Flush clears a pending load and discards a simultaneous one
    do_reset();
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    #1; tick();
    set_in(1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
    #1;
    check("flush_busy_before", 32'(busy_a), 32'd1);
    tick();
    set_in(1, 5, 1, 9, 1, 0, 0, 0, 0, 0);
    #1;
    check("flush_busy_after", 32'(busy_a), 32'd0);
    check("flush_haz_after",  32'(haz_a),  32'd0);
    tick();

    // Saturation: a self-dependent load stalls 2 of every 3 cycles
    do_reset();
    for (int i = 0; i < 31; i++) begin
      set_in(1, 5, 1, 0, 0, 5, 1, 1, 0, 0);
      #1; tick();
    end
    rst = 1'b1;
    #1;
    check("sat_haz",     32'(haz_a), 32'd1);
    check("sat_stall_a", 32'(sc_a),  32'd20);
    check("sat_stall_c", 32'(sc_c),  32'd15);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_haz",   32'(haz_a),  32'd0);
    check("rst_mid_busy",  32'(busy_a), 32'd0);
    check("rst_mid_stall", 32'(sc_a),   32'd0);
    check("rst_mid_stall_c", 32'(sc_c), 32'd0);
    tick();

    // Randomised traffic on a small register window, checked against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 3) != 0,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      #1; tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
